// File: rtl/present80_enc_core_if.sv
// present80_enc_core_if: bundle between the key/plaintext register block
// (master) and the PRESENT-80 encryption core (slave).
//   start_i      launch request from the control register
//   key_i        80-bit cipher key (bit 79 = MSB)
//   plaintext_i  64-bit plaintext block (bit 63 = MSB)
//   busy_o       rounds executing
//   done_o       one-cycle pulse when ciphertext_o is updated
//   valid_o      sticky: ciphertext_o holds a completed result
//   ciphertext_o 64-bit encryption result
interface present80_enc_core_if;
    logic        start_i;
    logic [79:0] key_i;
    logic [63:0] plaintext_i;
    logic        busy_o;
    logic        done_o;
    logic        valid_o;
    logic [63:0] ciphertext_o;

    modport master (
        output start_i,
        output key_i,
        output plaintext_i,
        input  busy_o,
        input  done_o,
        input  valid_o,
        input  ciphertext_o
    );

    modport slave (
        input  start_i,
        input  key_i,
        input  plaintext_i,
        output busy_o,
        output done_o,
        output valid_o,
        output ciphertext_o
    );
endinterface

// File: rtl/present80_enc_core.sv
// present80_enc_core: iterative PRESENT-80 encryption, one round per clock.
// Ports:
//   clk  clock
//   rst  synchronous, active-high reset
//   bus  slave side of present80_enc_core_if (start/key/plaintext in,
//        busy/done/valid/ciphertext out; all outputs registered)
// ROUNDS selects the number of SP rounds before the final key addition
// (1..31, 31 = standard PRESENT-80).
module present80_enc_core #(
    parameter int unsigned ROUNDS = 31
) (
    input  logic                       clk,
    input  logic                       rst,
    present80_enc_core_if.slave        bus
);

    localparam int unsigned BLK_W = 64;
    localparam int unsigned KEY_W = 80;
    localparam int unsigned RC_W  = 5;
    localparam int unsigned NIB_N = BLK_W / 4;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } fsm_t;

    // PRESENT 4-bit S-box
    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;
            4'h1: y = 4'h5;
            4'h2: y = 4'h6;
            4'h3: y = 4'hB;
            4'h4: y = 4'h9;
            4'h5: y = 4'h0;
            4'h6: y = 4'hA;
            4'h7: y = 4'hD;
            4'h8: y = 4'h3;
            4'h9: y = 4'hE;
            4'hA: y = 4'hF;
            4'hB: y = 4'h8;
            4'hC: y = 4'h4;
            4'hD: y = 4'h7;
            4'hE: y = 4'h1;
            default: y = 4'h2;
        endcase
        return y;
    endfunction

    // Bit permutation: bit i -> (16*i) mod 63, bit 63 fixed
    function automatic logic [BLK_W-1:0] p_layer(input logic [BLK_W-1:0] s);
        logic [BLK_W-1:0] r;
        r = '0;
        for (int i = 0; i < 63; i++) begin
            r[6'((i * 16) % 63)] = s[i];
        end
        r[63] = s[63];
        return r;
    endfunction

    // Key schedule step: rotate left 61, S-box top nibble, XOR round counter
    function automatic logic [KEY_W-1:0] key_update(input logic [KEY_W-1:0] k,
                                                    input logic [RC_W-1:0]  rc);
        logic [KEY_W-1:0] r;
        r          = {k[18:0], k[79:19]};
        r[79:76]   = sbox(r[79:76]);
        r[19:15]   = r[19:15] ^ rc;
        return r;
    endfunction

    fsm_t             fsm_q, fsm_d;
    logic [BLK_W-1:0] state_q, state_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic [RC_W-1:0]  rc_q, rc_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             valid_q, valid_d;
    logic [BLK_W-1:0] ct_q, ct_d;

    logic [BLK_W-1:0] sb_out;
    logic [BLK_W-1:0] round_out;
    logic [KEY_W-1:0] key_next;

    // Round datapath: addRoundKey -> sBoxLayer -> pLayer, plus next round key
    always_comb begin
        logic [BLK_W-1:0] mixed;
        mixed  = state_q ^ key_q[79:16];
        sb_out = '0;
        for (int n = 0; n < NIB_N; n++) begin
            sb_out[4*n +: 4] = sbox(mixed[4*n +: 4]);
        end
        round_out = p_layer(sb_out);
        key_next  = key_update(key_q, rc_q);
    end

    // Next-state and output logic
    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        key_d   = key_q;
        rc_d    = rc_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        valid_d = valid_q;
        ct_d    = ct_q;

        case (fsm_q)
            ST_IDLE: begin
                if (bus.start_i) begin
                    state_d = bus.plaintext_i;
                    key_d   = bus.key_i;
                    rc_d    = RC_W'(1);
                    busy_d  = 1'b1;
                    valid_d = 1'b0;
                    fsm_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                state_d = round_out;
                key_d   = key_next;
                rc_d    = rc_q + RC_W'(1);
                // Final round also applies the last round key (K32)
                if (rc_q == RC_W'(ROUNDS)) begin
                    ct_d    = round_out ^ key_next[79:16];
                    done_d  = 1'b1;
                    valid_d = 1'b1;
                    busy_d  = 1'b0;
                    fsm_d   = ST_IDLE;
                end
            end
            default: begin
                fsm_d = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= ST_IDLE;
            state_q <= '0;
            key_q   <= '0;
            rc_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            ct_q    <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            key_q   <= key_d;
            rc_q    <= rc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            valid_q <= valid_d;
            ct_q    <= ct_d;
        end
    end

    assign bus.busy_o       = busy_q;
    assign bus.done_o       = done_q;
    assign bus.valid_o      = valid_q;
    assign bus.ciphertext_o = ct_q;

endmodule

// File: tb/tb_present80_enc_core.sv
// tb_present80_enc_core: scoreboard bench for present80_enc_core using the
// published PRESENT-80 test vectors.
module tb_present80_enc_core;

    localparam logic [79:0] KEY_ZERO = 80'h0;
    localparam logic [79:0] KEY_ONES = {80{1'b1}};
    localparam logic [63:0] PT_ZERO  = 64'h0;
    localparam logic [63:0] PT_ONES  = {64{1'b1}};
    localparam logic [63:0] CT_00    = 64'h5579C1387B228445;
    localparam logic [63:0] CT_0F    = 64'hE72C46C0F5945049;
    localparam logic [63:0] CT_F0    = 64'hA112FFC72F68417B;
    localparam logic [63:0] CT_FF    = 64'h3333DCD3213210D2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    present80_enc_core_if bus ();

    present80_enc_core #(.ROUNDS(31)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          total    = 0;
    int          bad      = 0;
    int          done_cnt = 0;
    logic [63:0] exp_q[$];
    logic [63:0] mon_exp;

    // Scoreboard monitor: every done pulse pops one expected ciphertext
    always @(negedge clk) begin
        if (bus.done_o === 1'b1) begin
            done_cnt++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_done: got ct=%h with empty scoreboard", bus.ciphertext_o);
            end else begin
                mon_exp = exp_q.pop_front();
                if (bus.ciphertext_o !== mon_exp) begin
                    bad++;
                    $display("FAIL done_ct: got %h want %h", bus.ciphertext_o, mon_exp);
                end
            end
            total++;
            if (bus.valid_o !== 1'b1 || bus.busy_o !== 1'b0) begin
                bad++;
                $display("FAIL done_status: got valid=%b busy=%b want valid=1 busy=0",
                         bus.valid_o, bus.busy_o);
            end
        end
    end

    task automatic launch(input logic [63:0] pt, input logic [79:0] key, input logic [63:0] exp);
        bus.plaintext_i = pt;
        bus.key_i       = key;
        bus.start_i     = 1'b1;
        exp_q.push_back(exp);
        @(posedge clk); #1;
        bus.start_i = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        total++;
        if (done_cnt < target) begin
            bad++;
            $display("FAIL wait_done_timeout: got done_cnt=%0d want %0d", done_cnt, target);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0 || bus.valid_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_flags: got busy=%b done=%b valid=%b want 0 0 0",
                     bus.busy_o, bus.done_o, bus.valid_o);
        end
        total++;
        if (bus.ciphertext_o !== 64'h0) begin
            bad++;
            $display("FAIL reset_ct: got %h want 0", bus.ciphertext_o);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_vector(input string name, input logic [63:0] pt,
                               input logic [79:0] key, input logic [63:0] exp);
        int c0;
        c0 = done_cnt;
        launch(pt, key, exp);
        total++;
        if (bus.busy_o !== 1'b1 || bus.valid_o !== 1'b0) begin
            bad++;
            $display("FAIL %s_start: got busy=%b valid=%b want 1 0", name, bus.busy_o, bus.valid_o);
        end
        repeat (30) @(posedge clk);
        #1;
        total++;
        if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b1) begin
            bad++;
            $display("FAIL %s_early: got done=%b busy=%b at cycle 30 want 0 1", name, bus.done_o, bus.busy_o);
        end
        @(posedge clk); #1;
        total++;
        if (bus.done_o !== 1'b1 || bus.ciphertext_o !== exp) begin
            bad++;
            $display("FAIL %s_latency: got done=%b ct=%h at cycle 31 want 1 %h",
                     name, bus.done_o, bus.ciphertext_o, exp);
        end
        @(posedge clk); #1;
        total++;
        if (bus.done_o !== 1'b0 || bus.valid_o !== 1'b1 || bus.ciphertext_o !== exp
            || done_cnt !== c0 + 1) begin
            bad++;
            $display("FAIL %s_hold: got done=%b valid=%b ct=%h dones=%0d want 0 1 %h %0d",
                     name, bus.done_o, bus.valid_o, bus.ciphertext_o, done_cnt - c0, exp, 1);
        end
    endtask

    task automatic test_vectors();
        test_vector("v00", PT_ZERO, KEY_ZERO, CT_00);
        test_vector("v0f", PT_ZERO, KEY_ONES, CT_0F);
    endtask

    task automatic test_done_cycle_relaunch();
        launch(PT_ONES, KEY_ZERO, CT_F0);
        repeat (31) @(posedge clk);
        #1;
        total++;
        if (bus.done_o !== 1'b1) begin
            bad++;
            $display("FAIL relaunch_first_done: got done=%b want 1", bus.done_o);
        end
        bus.key_i   = KEY_ONES;
        bus.start_i = 1'b1;
        exp_q.push_back(CT_FF);
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        total++;
        if (bus.valid_o !== 1'b0 || bus.busy_o !== 1'b1 || bus.ciphertext_o !== CT_F0) begin
            bad++;
            $display("FAIL relaunch_start: got valid=%b busy=%b ct=%h want 0 1 %h",
                     bus.valid_o, bus.busy_o, bus.ciphertext_o, CT_F0);
        end
        repeat (30) @(posedge clk);
        #1;
        total++;
        if (bus.done_o !== 1'b0 || bus.ciphertext_o !== CT_F0) begin
            bad++;
            $display("FAIL relaunch_hold: got done=%b ct=%h want 0 %h", bus.done_o, bus.ciphertext_o, CT_F0);
        end
        @(posedge clk); #1;
        total++;
        if (bus.done_o !== 1'b1 || bus.ciphertext_o !== CT_FF) begin
            bad++;
            $display("FAIL relaunch_second: got done=%b ct=%h want 1 %h", bus.done_o, bus.ciphertext_o, CT_FF);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_start_ignored();
        int c0;
        c0 = done_cnt;
        launch(PT_ZERO, KEY_ZERO, CT_00);
        repeat (9) @(posedge clk);
        #1;
        bus.start_i     = 1'b1;
        bus.plaintext_i = PT_ONES;
        bus.key_i       = KEY_ONES;
        @(posedge clk); #1;
        bus.start_i     = 1'b0;
        bus.plaintext_i = 64'h0123456789ABCDEF;
        wait_done(c0 + 1, 40);
        repeat (40) @(posedge clk);
        #1;
        total++;
        if (done_cnt !== c0 + 1 || bus.busy_o !== 1'b0) begin
            bad++;
            $display("FAIL ignored_start: got dones=%0d busy=%b want 1 0", done_cnt - c0, bus.busy_o);
        end
    endtask

    task automatic test_reset_abort();
        int c0;
        launch(PT_ZERO, KEY_ONES, CT_0F);
        repeat (14) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        total++;
        if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0 || bus.valid_o !== 1'b0) begin
            bad++;
            $display("FAIL abort_flags: got busy=%b done=%b valid=%b want 0 0 0",
                     bus.busy_o, bus.done_o, bus.valid_o);
        end
        total++;
        if (bus.ciphertext_o !== 64'h0) begin
            bad++;
            $display("FAIL abort_ct: got %h want 0", bus.ciphertext_o);
        end
        rst = 1'b0;
        exp_q.delete();
        c0 = done_cnt;
        repeat (40) @(posedge clk);
        #1;
        total++;
        if (done_cnt !== c0 || bus.valid_o !== 1'b0) begin
            bad++;
            $display("FAIL abort_no_done: got dones=%0d valid=%b want 0 0", done_cnt - c0, bus.valid_o);
        end
        launch(PT_ONES, KEY_ONES, CT_FF);
        wait_done(c0 + 1, 40);
        total++;
        if (bus.ciphertext_o !== CT_FF || bus.valid_o !== 1'b1) begin
            bad++;
            $display("FAIL abort_restart: got ct=%h valid=%b want %h 1", bus.ciphertext_o, bus.valid_o, CT_FF);
        end
    endtask

    task automatic test_back_to_back();
        int cycles;
        int busy_err;
        bus.plaintext_i = PT_ZERO;
        bus.key_i       = KEY_ZERO;
        bus.start_i     = 1'b1;
        exp_q.push_back(CT_00);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            cycles   = 0;
            busy_err = 0;
            while (bus.done_o !== 1'b1 && cycles < 40) begin
                if (bus.busy_o !== 1'b1) busy_err++;
                @(posedge clk); #1;
                cycles++;
            end
            total++;
            if (cycles != 31 || busy_err != 0) begin
                bad++;
                $display("FAIL b2b_period%0d: got cycles=%0d busy_gaps=%0d want 31 0", k, cycles, busy_err);
            end
            total++;
            if (bus.busy_o !== 1'b0 || bus.ciphertext_o !== CT_00) begin
                bad++;
                $display("FAIL b2b_done%0d: got busy=%b ct=%h want 0 %h", k, bus.busy_o, bus.ciphertext_o, CT_00);
            end
            if (k < 2) exp_q.push_back(CT_00);
            else bus.start_i = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (bus.busy_o !== 1'b0 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL b2b_stop: got busy=%b pending=%0d want 0 0", bus.busy_o, exp_q.size());
        end
    endtask

    initial begin
        bus.start_i     = 1'b0;
        bus.key_i       = '0;
        bus.plaintext_i = '0;
        rst             = 1'b1;
        test_reset();
        test_vectors();
        test_done_cycle_relaunch();
        test_start_ignored();
        test_reset_abort();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
